game_binary_quiz_n: RTL and testbench



---
 rtl/game_pkg.sv | 18 +
 rtl/btn_edge_enc.sv | 40 ++++
 rtl/game_binary_quiz_n.sv | 182 ++++++++++++++++++
 tb/tb_game_binary_quiz_n.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared value codes and FSM state type for the binary quiz game.
package game_pkg;

    localparam logic [3:0] SEG_CORRECT  = 4'd10;
    localparam logic [3:0] SEG_ERROR    = 4'd11;
    localparam logic [3:0] SEG_BLANK    = 4'd12;
    localparam logic [3:0] SEG_QUESTION = 4'd13;

    typedef enum logic [2:0] {
        IDLE,
        SHOW_BIT,
        GAP,
        QUIZ,
        RESULT,
        SCORE
    } state_e;

endpackage

// File: rtl/btn_edge_enc.sv
// Rising-edge detector for the answer buttons with lowest-index priority encoding.
// arm_i reloads the history with all ones so buttons already held are ignored.
module btn_edge_enc #(
    parameter int unsigned NBTN  = 7,
    parameter int unsigned NUM_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [NBTN-1:0]  btn_i,
    input  logic             arm_i,
    output logic             press_valid_o,
    output logic [NUM_W-1:0] press_num_o
);

    logic [NBTN-1:0] btn_prev_q, btn_prev_d;
    logic [NBTN-1:0] evt;

    always_comb begin
        evt           = btn_i & ~btn_prev_q;
        btn_prev_d    = arm_i ? {NBTN{1'b1}} : btn_i;
        press_valid_o = 1'b0;
        press_num_o   = '0;
        // Scan high to low so the lowest set index is the last write.
        for (int i = NBTN - 1; i >= 0; i--) begin
            if (evt[i]) begin
                press_valid_o = 1'b1;
                press_num_o   = NUM_W'(i + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            btn_prev_q <= {NBTN{1'b1}};
        end else begin
            btn_prev_q <= btn_prev_d;
        end
    end

endmodule

// File: rtl/game_binary_quiz_n.sv
// Binary quiz game: shows an NBITS random number bit by bit, grades the answer, shows score.
// Optional answer timeout is enabled by defining QUIZ_TIMEOUT_EN.
module game_binary_quiz_n
    import game_pkg::*;
#(
    parameter int unsigned NBITS        = 3,
    parameter int unsigned NBTN         = 2**NBITS - 1,
    parameter int unsigned ROUNDS       = 5,
    parameter int unsigned BIT_TIME     = 10_000_000,
    parameter int unsigned GAP_TIME     = 2_000_000,
    parameter int unsigned RESULT_TIME  = 10_000_000,
    parameter int unsigned QUIZ_TIMEOUT = 50_000_000,
    parameter int unsigned CNT_W        = 26
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [NBTN-1:0] btn,
    input  logic [3:0]      rnd,
    output logic [3:0]      value,
    output logic            busy
);

    state_e             state_q, state_d;
    logic [3:0]         value_q, value_d;
    logic               busy_q, busy_d;
    logic [3:0]         score_q, score_d;
    logic [3:0]         round_q, round_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         bit_idx_q, bit_idx_d;
    logic [NBITS-1:0]   target_q, target_d;
    logic [NBITS-1:0]   new_target;
    logic               arm;
    logic               press_valid;
    logic [3:0]         press_num;

    btn_edge_enc #(
        .NBTN  (NBTN),
        .NUM_W (4)
    ) u_btn_edge_enc (
        .clk           (clk),
        .reset_n       (reset_n),
        .btn_i         (btn),
        .arm_i         (arm),
        .press_valid_o (press_valid),
        .press_num_o   (press_num)
    );

    // A zero draw would be unanswerable, so it is replaced by all ones.
    assign new_target = (rnd[NBITS-1:0] == '0) ? {NBITS{1'b1}} : rnd[NBITS-1:0];

    always_comb begin
        state_d   = state_q;
        value_d   = value_q;
        score_d   = score_q;
        round_d   = round_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        target_d  = target_q;
        arm       = 1'b0;
        case (state_q)
            IDLE: begin
                value_d = SEG_BLANK;
                cnt_d   = '0;
                if (press_valid) begin
                    state_d   = SHOW_BIT;
                    bit_idx_d = 2'(NBITS - 1);
                    target_d  = new_target;
                    value_d   = {3'b000, new_target[NBITS-1]};
                end
            end
            SHOW_BIT: begin
                if (cnt_q == CNT_W'(BIT_TIME - 1)) begin
                    state_d = GAP;
                    cnt_d   = '0;
                    value_d = SEG_BLANK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == CNT_W'(GAP_TIME - 1)) begin
                    cnt_d = '0;
                    if (bit_idx_q == 2'd0) begin
                        state_d = QUIZ;
                        value_d = SEG_QUESTION;
                        arm     = 1'b1;
                    end else begin
                        state_d   = SHOW_BIT;
                        bit_idx_d = bit_idx_q - 2'd1;
                        value_d   = {3'b000, target_q[bit_idx_q - 2'd1]};
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            QUIZ: begin
                if (press_valid) begin
                    state_d = RESULT;
                    cnt_d   = '0;
                    if (press_num == 4'(target_q)) begin
                        value_d = SEG_CORRECT;
                        score_d = score_q + 4'd1;
                    end else begin
                        value_d = SEG_ERROR;
                    end
`ifdef QUIZ_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(QUIZ_TIMEOUT - 1)) begin
                    state_d = RESULT;
                    cnt_d   = '0;
                    value_d = SEG_ERROR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`else
                end else begin
                    cnt_d = '0;
                end
`endif
            end
            RESULT: begin
                if (cnt_q == CNT_W'(RESULT_TIME - 1)) begin
                    cnt_d   = '0;
                    round_d = round_q + 4'd1;
                    if (round_q + 4'd1 == 4'(ROUNDS)) begin
                        state_d = SCORE;
                        value_d = score_q;
                    end else begin
                        state_d   = SHOW_BIT;
                        bit_idx_d = 2'(NBITS - 1);
                        target_d  = new_target;
                        value_d   = {3'b000, new_target[NBITS-1]};
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SCORE: begin
                if (cnt_q == CNT_W'(RESULT_TIME - 1)) begin
                    state_d = IDLE;
                    value_d = SEG_BLANK;
                    cnt_d   = '0;
                    score_d = '0;
                    round_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                value_d = SEG_BLANK;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            value_q   <= SEG_BLANK;
            busy_q    <= 1'b0;
            score_q   <= '0;
            round_q   <= '0;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            target_q  <= '0;
        end else begin
            state_q   <= state_d;
            value_q   <= value_d;
            busy_q    <= busy_d;
            score_q   <= score_d;
            round_q   <= round_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            target_q  <= target_d;
        end
    end

    assign value = value_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_game_binary_quiz_n.sv
// Directed scoreboard bench for game_binary_quiz_n (NBITS=3, ROUNDS=2, short timings).
module tb_game_binary_quiz_n;

    logic       clk;
    logic       reset_n;
    logic [6:0] btn;
    logic [3:0] rnd;
    logic [3:0] value;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] v;
        logic       b;
    } exp_t;

    exp_t sb[$];

    game_binary_quiz_n #(
        .NBITS        (3),
        .ROUNDS       (2),
        .BIT_TIME     (4),
        .GAP_TIME     (2),
        .RESULT_TIME  (4),
        .QUIZ_TIMEOUT (20),
        .CNT_W        (26)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .btn     (btn),
        .rnd     (rnd),
        .value   (value),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] v, input logic b, input int n);
        exp_t e;
        e.v = v;
        e.b = b;
        for (int i = 0; i < n; i++) sb.push_back(e);
    endtask

    // One clock per queued entry; the DUT output after each edge is popped and compared.
    task automatic drain(input string tag);
        exp_t e;
        int   step;
        step = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            tick();
            check($sformatf("%s[%0d].value", tag, step), value, e.v);
            check($sformatf("%s[%0d].busy", tag, step), {3'b000, busy}, {3'b000, e.b});
            step++;
        end
    endtask

    // Expected display for one round: three bits with gaps, then two '?' cycles.
    task automatic show_seq(input logic [2:0] t);
        for (int i = 2; i >= 0; i--) begin
            push({3'b000, t[i]}, 1'b1, 4);
            push(4'd12, 1'b1, 2);
        end
        push(4'd13, 1'b1, 2);
    endtask

    initial begin
        reset_n = 1'b0;
        btn     = '0;
        rnd     = 4'd5;
        tick();
        tick();
        check("reset.value", value, 4'd12);
        check("reset.busy", {3'b000, busy}, 4'd0);
        reset_n = 1'b1;
        push(4'd12, 1'b0, 1);
        drain("idle0");

        // Reset taken mid-SHOW_BIT.
        btn = 7'b0000001;
        push(4'd1, 1'b1, 2);
        drain("pre_reset");
        btn = '0;
        reset_n = 1'b0;
        tick();
        tick();
        check("midreset.value", value, 4'd12);
        check("midreset.busy", {3'b000, busy}, 4'd0);
        reset_n = 1'b1;
        push(4'd12, 1'b0, 3);
        drain("idle_after_reset");

        // Game 1: target 5 answered correctly, then target 7 (rnd=0) answered wrong.
        rnd = 4'd5;
        btn = 7'b0000001;
        show_seq(3'd5);
        drain("g1r0_show");
        btn = 7'b0010000;
        push(4'd10, 1'b1, 1);
        drain("g1r0_press");
        btn = '0;
        rnd = 4'd0;
        push(4'd10, 1'b1, 3);
        show_seq(3'd7);
        drain("g1r1_show");
        btn = 7'b0000100;
        push(4'd11, 1'b1, 1);
        drain("g1r1_press");
        btn = '0;
        push(4'd11, 1'b1, 3);
        push(4'd1, 1'b1, 4);
        push(4'd12, 1'b0, 2);
        drain("g1_score");

        // Game 2: target 6 correct; target 2 with held and simultaneous buttons.
        rnd = 4'd6;
        btn = 7'b0000001;
        show_seq(3'd6);
        drain("g2r0_show");
        btn = 7'b0100000;
        push(4'd10, 1'b1, 1);
        drain("g2r0_press");
        rnd = 4'd2;
        btn = 7'b0010000;
        push(4'd10, 1'b1, 3);
        show_seq(3'd2);
        push(4'd13, 1'b1, 5);
        drain("g2r1_held");
        btn = '0;
        push(4'd13, 1'b1, 1);
        drain("g2r1_release");
        btn = 7'b0010010;
        push(4'd10, 1'b1, 1);
        drain("g2r1_press");
        btn = '0;
        push(4'd10, 1'b1, 3);
        push(4'd2, 1'b1, 4);
        push(4'd12, 1'b0, 2);
        drain("g2_score");

        // Game 3: answer timeout behaviour.
        rnd = 4'd1;
        btn = 7'b0000001;
        show_seq(3'd1);
        drain("g3r0_show");
        btn = '0;
`ifdef QUIZ_TIMEOUT_EN
        push(4'd13, 1'b1, 18);
        push(4'd11, 1'b1, 4);
        drain("g3_timeout");
`else
        push(4'd13, 1'b1, 100);
        drain("g3_wait");
        btn = 7'b0000001;
        push(4'd10, 1'b1, 4);
        drain("g3_late_press");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
